// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan serializer: FSM states and widths.
package mux_scan_pkg;

  localparam int unsigned N_INPUTS = 8;  // mux data inputs / bits per word
  localparam int unsigned SEL_W    = 3;  // mux select width
  localparam int unsigned HOLD_W   = 4;  // hold counter width (HOLD_CYCLES up to 16)

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer: accepts an 8-bit word on a valid/ready handshake, drives it
// onto an external 8-to-1 mux, steps the mux select through all positions and
// samples the mux output once per position to produce a serial bitstream.
//
// Parameters:
//   HOLD_CYCLES  cycles each select value is held before sampling (1..16)
//   MSB_FIRST    0: select steps 0..7, 1: select steps 7..0
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_data      word to serialize
//   in_valid     in_data is valid
//   in_ready     block can accept a word (state == IDLE)
//   mux_a        registered copy of the accepted word, to the mux data inputs
//   mux_sel      registered mux select
//   mux_f        mux output fed back for sampling
//   ser_out      sampled serial bit
//   ser_valid    one-cycle pulse, ser_out holds a new bit
//   ser_last     high with ser_valid on the 8th bit of a word
//   busy         scan in progress (state == SCAN)
module mux_scan_serializer
  import mux_scan_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter bit          MSB_FIRST   = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_INPUTS-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [N_INPUTS-1:0] mux_a,
  output logic [SEL_W-1:0]    mux_sel,
  input  logic                mux_f,
  output logic                ser_out,
  output logic                ser_valid,
  output logic                ser_last,
  output logic                busy
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SEL_W-1:0]  BIT_LAST  = SEL_W'(N_INPUTS - 1);
  localparam logic [SEL_W-1:0]  SEL_START = MSB_FIRST ? SEL_W'(N_INPUTS - 1) : '0;

  state_e                state, state_d;
  logic [HOLD_W-1:0]     hold_cnt, hold_cnt_d;
  logic [SEL_W-1:0]      bit_cnt, bit_cnt_d;
  logic [N_INPUTS-1:0]   mux_a_d;
  logic [SEL_W-1:0]      mux_sel_d;
  logic                  ser_out_d, ser_valid_d, ser_last_d;

  // Status is a direct decode of the state register.
  assign in_ready = (state == IDLE);
  assign busy     = (state == SCAN);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      bit_cnt   <= '0;
      mux_a     <= '0;
      mux_sel   <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      state     <= state_d;
      hold_cnt  <= hold_cnt_d;
      bit_cnt   <= bit_cnt_d;
      mux_a     <= mux_a_d;
      mux_sel   <= mux_sel_d;
      ser_out   <= ser_out_d;
      ser_valid <= ser_valid_d;
      ser_last  <= ser_last_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    hold_cnt_d  = hold_cnt;
    bit_cnt_d   = bit_cnt;
    mux_a_d     = mux_a;
    mux_sel_d   = mux_sel;
    ser_out_d   = ser_out;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          state_d    = SCAN;
          mux_a_d    = in_data;
          bit_cnt_d  = '0;
          hold_cnt_d = '0;
          mux_sel_d  = SEL_START;
        end
      end

      SCAN: begin
        if (hold_cnt != HOLD_LAST) begin
          hold_cnt_d = HOLD_W'(hold_cnt + 1'b1);
        end else begin
          // Select has settled for HOLD_CYCLES: sample the mux output.
          ser_out_d   = mux_f;
          ser_valid_d = 1'b1;
          ser_last_d  = (bit_cnt == BIT_LAST);
          hold_cnt_d  = '0;
          if (bit_cnt == BIT_LAST) begin
            state_d = IDLE;
          end else begin
            bit_cnt_d = SEL_W'(bit_cnt + 1'b1);
            mux_sel_d = MSB_FIRST ? SEL_W'(mux_sel - 1'b1) : SEL_W'(mux_sel + 1'b1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer: four instances (HOLD 1/3 x LSB/MSB first), each
// closed through a behavioural 8-to-1 mux, checked against a timing model that
// derives every expected output from the accept edge and elapsed edge count.
module tb_mux_scan_serializer;

  localparam int NI = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data  [NI];
  logic       in_valid [NI];
  logic       in_ready [NI];
  logic [7:0] mux_a    [NI];
  logic [2:0] mux_sel  [NI];
  logic       mux_f    [NI];
  logic       ser_out  [NI];
  logic       ser_valid[NI];
  logic       ser_last [NI];
  logic       busy     [NI];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned hold_of(input int i);
    return (i < 2) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned H   = (g < 2) ? 1 : 3;
    localparam bit          MSB = (g % 2) == 1;

    mux_scan_serializer #(.HOLD_CYCLES(H), .MSB_FIRST(MSB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .mux_a    (mux_a[g]),
      .mux_sel  (mux_sel[g]),
      .mux_f    (mux_f[g]),
      .ser_out  (ser_out[g]),
      .ser_valid(ser_valid[g]),
      .ser_last (ser_last[g]),
      .busy     (busy[g])
    );

    // The lab 8-to-1 mux.
    assign mux_f[g] = mux_a[g][mux_sel[g]];

    function automatic int unsigned pos(input int unsigned k);
      return MSB ? 7 - k : k;
    endfunction

    // Reference model: word scanned at edges age = H, 2H, ... 8H after accept.
    bit          m_act;
    int unsigned m_age;
    logic [7:0]  m_word;
    logic [7:0]  e_a;
    logic [2:0]  e_sel;
    logic        e_out, e_valid, e_last, e_busy;

    always @(posedge clk or negedge rst_n) begin : model
      int unsigned d;
      logic [7:0]  w;
      bit          acc, pulse;
      if (!rst_n) begin
        m_act <= 1'b0; m_age <= 0; m_word <= 8'h00;
        e_a <= 8'h00; e_sel <= 3'd0; e_out <= 1'b0;
        e_valid <= 1'b0; e_last <= 1'b0; e_busy <= 1'b0;
      end else begin
        acc = !m_act && in_valid[g];
        if (acc || m_act) begin
          d     = acc ? 0 : m_age + 1;
          w     = acc ? in_data[g] : m_word;
          pulse = (d >= H) && (d % H == 0);
          e_valid <= pulse;
          e_last  <= pulse && (d == 8 * H);
          if (pulse) e_out <= w[pos(d / H - 1)];
          e_busy  <= d < 8 * H;
          e_sel   <= 3'(pos((d < 8 * H) ? d / H : 7));
          if (acc) e_a <= in_data[g];
          m_act  <= d < 8 * H;
          m_age  <= d;
          m_word <= w;
        end else begin
          e_valid <= 1'b0;
          e_last  <= 1'b0;
          e_busy  <= 1'b0;
        end
      end
    end

    // Cycle-by-cycle comparison plus reassembly of each serialized word.
    logic bits[$];
    always @(negedge clk) begin : monitor
      logic [7:0] rebuilt;
      check($sformatf("i%0d in_ready", g),  32'(in_ready[g]),  32'(!e_busy));
      check($sformatf("i%0d busy", g),      32'(busy[g]),      32'(e_busy));
      check($sformatf("i%0d ser_valid", g), 32'(ser_valid[g]), 32'(e_valid));
      check($sformatf("i%0d ser_last", g),  32'(ser_last[g]),  32'(e_last));
      check($sformatf("i%0d ser_out", g),   32'(ser_out[g]),   32'(e_out));
      check($sformatf("i%0d mux_sel", g),   32'(mux_sel[g]),   32'(e_sel));
      check($sformatf("i%0d mux_a", g),     32'(mux_a[g]),     32'(e_a));
      if (!rst_n) begin
        bits.delete();
      end else if (ser_valid[g]) begin
        bits.push_back(ser_out[g]);
        if (ser_last[g]) begin
          rebuilt = 8'h00;
          for (int j = 0; j < bits.size() && j < 8; j++) rebuilt[pos(j)] = bits[j];
          check($sformatf("i%0d bit_count", g), 32'(bits.size()), 32'd8);
          check($sformatf("i%0d word", g),      32'(rebuilt),     32'(m_word));
          bits.delete();
        end
      end
    end
  end

  task automatic wait_ready(input int i);
    int n = 0;
    while (!in_ready[i] && n < 400) begin
      @(negedge clk);
      in_data[i] = 8'($urandom);  // changes during a scan must be ignored
      n++;
    end
    check($sformatf("i%0d wait_ready", i), 32'(in_ready[i]), 32'd1);
  endtask

  task automatic send(input int i, input logic [7:0] w);
    @(negedge clk);
    wait_ready(i);
    in_data[i]  = w;
    in_valid[i] = 1'b1;
    @(negedge clk);
    in_valid[i] = 1'b0;
  endtask

  // in_valid held high across two words; second accept follows 8*H+1 edges later.
  task automatic held_pair(input int i);
    int n;
    @(negedge clk);
    wait_ready(i);
    in_data[i]  = 8'hFF;
    in_valid[i] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 3) in_data[i] = 8'h00;
    end while (!in_ready[i] && n < 400);
    check($sformatf("i%0d accept_gap", i), 32'(n), 32'(8 * hold_of(i) + 1));
    @(negedge clk);
    in_valid[i] = 1'b0;
    wait_ready(i);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    for (int i = 0; i < NI; i++) begin
      in_data[i]  = 8'h00;
      in_valid[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: nothing happens for 20 cycles.
    repeat (20) @(negedge clk);
    for (int i = 0; i < NI; i++) check($sformatf("i%0d idle_sel", i), 32'(mux_sel[i]), 32'd0);

    // Directed words on every configuration.
    for (int i = 0; i < NI; i++) begin
      send(i, 8'hC1);
      wait_ready(i);
      send(i, 8'h5A);
      wait_ready(i);
      held_pair(i);
    end

    // Randomized words with random gaps, all instances in turn.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NI; i++) begin
        send(i, 8'($urandom));
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
    end
    for (int i = 0; i < NI; i++) wait_ready(i);

    // Reset in the middle of a word, while a ser_valid pulse is showing.
    send(0, 8'hAA);
    n = 0;
    while (n < 4) begin
      @(negedge clk);
      if (ser_valid[0]) n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("rst ser_valid", 32'(ser_valid[0]), 32'd0);
    check("rst ser_last",  32'(ser_last[0]),  32'd0);
    check("rst mux_a",     32'(mux_a[0]),     32'd0);
    check("rst mux_sel",   32'(mux_sel[0]),   32'd0);
    check("rst busy",      32'(busy[0]),      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(0, 8'h01);
    send(1, 8'h01);
    send(2, 8'h80);
    send(3, 8'h80);
    for (int i = 0; i < NI; i++) wait_ready(i);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
